// File: rtl/timer_button_panel.sv
// rtl/timer_button_panel.sv - debounced button front end and run-state tracker for countdownTimer
// Optional: define PANEL_PAUSE_TOGGLE_EN so that pause while PAUSED resumes the count.
module timer_button_panel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_restart,
    input  logic [5:0] sw_in,
    input  logic       timer_done,
    output logic [5:0] in_val,
    output logic       start_con,
    output logic       pause,
    output logic       restart,
    output logic [1:0] panel_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order for all per-button vectors: [0] start, [1] pause, [2] restart.
    logic [2:0]       sync1, sync2, deb, deb_q;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       press;
    logic [5:0]       sw_q;

    state_t state, state_d;
    logic   cmd_start, cmd_pause, cmd_restart;
    logic   start_d, pause_d, restart_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {btn_restart, btn_pause, btn_start};
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_q;

    // Coincident presses resolve before the FSM sees them; losers are simply gone.
    assign cmd_restart = press[2];
    assign cmd_pause   = press[1] & ~press[2];
    assign cmd_start   = press[0] & ~press[1] & ~press[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            start_con <= 1'b0;
            pause     <= 1'b0;
            restart   <= 1'b0;
            sw_q      <= '0;
            in_val    <= '0;
        end else begin
            state     <= state_d;
            start_con <= start_d;
            pause     <= pause_d;
            restart   <= restart_d;
            sw_q      <= sw_in;
            if (state == IDLE) in_val <= sw_q;
        end
    end

    always_comb begin
        state_d = state;
        if (cmd_restart) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (cmd_start) state_d = RUNNING;
                RUNNING: begin
                    if (timer_done)     state_d = IDLE;
                    else if (cmd_pause) state_d = PAUSED;
                end
                PAUSED: begin
                    if (cmd_start) state_d = RUNNING;
`ifdef PANEL_PAUSE_TOGGLE_EN
                    else if (cmd_pause) state_d = RUNNING;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Expiry outranks a same-cycle pause; only restart beats expiry.
    always_comb begin
        restart_d = cmd_restart;
        pause_d   = (state == RUNNING) && !timer_done && cmd_pause;
        start_d   = ((state == IDLE) || (state == PAUSED)) && cmd_start;
`ifdef PANEL_PAUSE_TOGGLE_EN
        if ((state == PAUSED) && cmd_pause) start_d = 1'b1;
`endif
    end

    assign panel_state = state;

endmodule

// File: tb/tb_timer_button_panel.sv
// tb/tb_timer_button_panel.sv - randomized self-checking bench for timer_button_panel
module tb_timer_button_panel;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0, btn_pause = 1'b0, btn_restart = 1'b0;
    logic [5:0] sw_in = '0;
    logic       timer_done = 1'b0;
    logic [5:0] in_val;
    logic       start_con, pause, restart;
    logic [1:0] panel_state;

    int checks = 0;
    int errors = 0;

    int         m_state = 0;
    logic [5:0] m_in_val = '0;

    timer_button_panel #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_restart(btn_restart),
        .sw_in(sw_in), .timer_done(timer_done),
        .in_val(in_val), .start_con(start_con), .pause(pause), .restart(restart),
        .panel_state(panel_state)
    );

    always #20 clk = ~clk;

    // mask/pulse bits: [2] restart, [1] pause, [0] start. States: 0 idle, 1 running, 2 paused.
    function automatic int model_step(input int st, input logic [2:0] mask, output logic [2:0] pulse);
        pulse = 3'b000;
        if (mask[2]) begin
            pulse = 3'b100;
            return 0;
        end
        if (mask[1]) begin
            if (st == 1) begin
                pulse = 3'b010;
                return 2;
            end
`ifdef PANEL_PAUSE_TOGGLE_EN
            if (st == 2) begin
                pulse = 3'b001;
                return 1;
            end
`endif
            return st;
        end
        if (mask[0] && st != 1) begin
            pulse = 3'b001;
            return 1;
        end
        return st;
    endfunction

    task automatic do_press(input logic [2:0] mask, input int hold, input logic [5:0] sw, input string name);
        logic [2:0] exp_pulse;
        logic [2:0] got;
        int         nxt;
        @(negedge clk);
        sw_in = sw;
        if (hold >= D) begin
            nxt = model_step(m_state, mask, exp_pulse);
        end else begin
            nxt = m_state;
            exp_pulse = 3'b000;
        end
        {btn_restart, btn_pause, btn_start} = mask;
        for (int i = 1; i <= hold + D + 8; i++) begin
            @(negedge clk);
            got = {restart, pause, start_con};
            checks++;
            if (got !== ((i == D + 3) ? exp_pulse : 3'b000)) begin
                errors++;
                $display("FAIL %s pulses cycle %0d got %b expected %b", name, i, got,
                         (i == D + 3) ? exp_pulse : 3'b000);
            end
            if (i == hold) {btn_restart, btn_pause, btn_start} = 3'b000;
        end
        if (m_state == 0 || nxt == 0) m_in_val = sw;
        m_state = nxt;
        checks++;
        if (panel_state !== 2'(m_state)) begin
            errors++;
            $display("FAIL %s state got %0d expected %0d", name, panel_state, m_state);
        end
        checks++;
        if (in_val !== m_in_val) begin
            errors++;
            $display("FAIL %s in_val got %0d expected %0d", name, in_val, m_in_val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_in = 6'd10;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_val, start_con, pause, restart, panel_state} !== 11'd0) begin
            errors++;
            $display("FAIL reset outputs got %b expected 0", {in_val, start_con, pause, restart, panel_state});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_val !== 6'd10) begin
            errors++;
            $display("FAIL reset in_val got %0d expected 10", in_val);
        end
        checks++;
        if ({start_con, pause, restart, panel_state} !== 5'd0) begin
            errors++;
            $display("FAIL reset idle got %b expected 0", {start_con, pause, restart, panel_state});
        end
        m_state = 0;
        m_in_val = 6'd10;
    endtask

    task automatic test_start();
        do_press(3'b001, 10, 6'd10, "start");
    endtask

    task automatic test_pause_glitch();
        do_press(3'b010, 3, 6'd10, "pause_glitch");
        do_press(3'b010, 10, 6'd10, "pause");
        @(negedge clk);
        sw_in = 6'd21;
        repeat (4) @(negedge clk);
        checks++;
        if (in_val !== 6'd10) begin
            errors++;
            $display("FAIL frozen in_val got %0d expected 10", in_val);
        end
    endtask

    task automatic test_restart_priority();
        do_press(3'b101, 10, 6'd21, "restart_over_start");
    endtask

    task automatic test_timer_done();
        do_press(3'b001, 10, 6'd21, "start_for_done");
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        m_state = 0;
        checks++;
        if ({panel_state, start_con, pause, restart} !== 5'd0) begin
            errors++;
            $display("FAIL timer_done got %b expected 0", {panel_state, start_con, pause, restart});
        end
        do_press(3'b010, 10, 6'd21, "pause_in_idle");
    endtask

    task automatic test_pause_toggle();
        do_press(3'b001, 10, 6'd33, "toggle_start");
        do_press(3'b010, 10, 6'd33, "toggle_pause");
        do_press(3'b010, 10, 6'd33, "toggle_second_pause");
        do_press(3'b100, 10, 6'd33, "toggle_restart");
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_pulse;
        int         nxt;
        do_press(3'b001, 10, 6'd7, "mid_start");
        @(negedge clk);
        reset = 1'b1;
        btn_start = 1'b1;
        #1;
        checks++;
        if ({panel_state, start_con, pause, restart} !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid got %b expected 0", {panel_state, start_con, pause, restart});
        end
        @(negedge clk);
        reset = 1'b0;
        m_state = 0;
        nxt = model_step(m_state, 3'b001, exp_pulse);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if ({restart, pause, start_con} !== ((i == D + 3) ? exp_pulse : 3'b000)) begin
                errors++;
                $display("FAIL held_across_reset cycle %0d got %b", i, {restart, pause, start_con});
            end
            if (i == 10) btn_start = 1'b0;
        end
        m_state = nxt;
        m_in_val = sw_in;
        checks++;
        if (panel_state !== 2'd1 || in_val !== m_in_val) begin
            errors++;
            $display("FAIL held_across_reset state %0d in_val %0d expected 1 %0d", panel_state, in_val, m_in_val);
        end
    endtask

    task automatic test_random();
        logic [2:0] mask;
        int         hold;
        for (int n = 0; n < 30; n++) begin
            mask = 3'($urandom_range(1, 7));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 12);
            do_press(mask, hold, 6'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_glitch();
        test_restart_priority();
        test_timer_done();
        test_pause_toggle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
